// File: rtl/noc_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_router_pkg
// Purpose  : Shared types and helpers for the NoC router output allocators.
// Revision : 1.0 - initial release
// ============================================================================
package noc_router_pkg;

   typedef enum logic [0:0] {
      ALLOC_IDLE   = 1'b0,
      ALLOC_LOCKED = 1'b1
   } alloc_state_t;

   // Bits needed to hold a credit count ranging over 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : noc_router_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_INPUTS = 5,
   parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic [IDX_WIDTH-1:0]  i_ptr,
   output logic [NUM_INPUTS-1:0] o_grant,
   output logic [IDX_WIDTH-1:0]  o_grant_idx,
   output logic                  o_grant_valid
);

   localparam logic [IDX_WIDTH:0] c_num = (IDX_WIDTH+1)'(NUM_INPUTS);

   logic [IDX_WIDTH:0] w_pos;

   always_comb begin
      o_grant       = '0;
      o_grant_idx   = '0;
      o_grant_valid = 1'b0;
      w_pos         = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         // ptr + k never exceeds 2*NUM_INPUTS-2, so a single subtract wraps it.
         w_pos = {1'b0, i_ptr} + (IDX_WIDTH+1)'(k);
         if (w_pos >= c_num) begin
            w_pos = w_pos - c_num;
         end
         if (!o_grant_valid && i_req[w_pos[IDX_WIDTH-1:0]]) begin
            o_grant_valid                     = 1'b1;
            o_grant_idx                       = w_pos[IDX_WIDTH-1:0];
            o_grant[w_pos[IDX_WIDTH-1:0]]     = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/output_port_allocator.sv
`default_nettype none
// ============================================================================
// Module   : output_port_allocator
// Purpose  : Wormhole output allocator with round-robin arbitration, packet
//            locking and credit-based downstream flow control.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_allocator
   import noc_router_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 2,
   localparam int CREDIT_WIDTH     = credit_width(FLIT_BUFFER_DEPTH),
   localparam int IDX_WIDTH        = $clog2(NUM_INPUTS)
) (
   input  logic                    clk_noc,
   input  logic                    rst_noc,
   input  logic [NUM_INPUTS-1:0]   req,
   input  logic [NUM_INPUTS-1:0]   req_is_tail,
   input  logic                    credit_in,
   output logic [NUM_INPUTS-1:0]   grant,
   output logic                    send_out,
   output logic                    is_tail_out,
   output logic [CREDIT_WIDTH-1:0] credit_count,
   output logic                    locked,
   output logic [IDX_WIDTH-1:0]    owner,
   output logic                    credit_overflow
);

   localparam logic [CREDIT_WIDTH-1:0] c_full    = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] c_one     = CREDIT_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]    c_last    = IDX_WIDTH'(NUM_INPUTS - 1);

   alloc_state_t            r_state, w_state_nxt;
   logic [IDX_WIDTH-1:0]    r_ptr, w_ptr_nxt;
   logic [IDX_WIDTH-1:0]    r_owner, w_owner_nxt;
   logic [CREDIT_WIDTH-1:0] r_credit;
   logic                    r_overflow;

   logic [NUM_INPUTS-1:0]   w_arb_grant;
   logic [IDX_WIDTH-1:0]    w_arb_idx;
   logic                    w_arb_valid;
   logic [NUM_INPUTS-1:0]   w_grant;
   logic                    w_send;
   logic                    w_has_credit;

   function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
      return (idx == c_last) ? '0 : idx + IDX_WIDTH'(1);
   endfunction

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_rr_arbiter (
      .i_req         (req),
      .i_ptr         (r_ptr),
      .o_grant       (w_arb_grant),
      .o_grant_idx   (w_arb_idx),
      .o_grant_valid (w_arb_valid)
   );

   assign w_has_credit = (r_credit != '0);

   always_comb begin
      w_grant     = '0;
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      case (r_state)
         ALLOC_IDLE: begin
            if (w_has_credit && w_arb_valid) begin
               w_grant = w_arb_grant;
               if (req_is_tail[w_arb_idx]) begin
                  w_ptr_nxt = wrap_inc(w_arb_idx);
               end else begin
                  w_state_nxt = ALLOC_LOCKED;
                  w_owner_nxt = w_arb_idx;
               end
            end
         end
         ALLOC_LOCKED: begin
            // Other inputs are ignored until the owner's tail has left.
            if (w_has_credit && req[r_owner]) begin
               w_grant[r_owner] = 1'b1;
               if (req_is_tail[r_owner]) begin
                  w_state_nxt = ALLOC_IDLE;
                  w_ptr_nxt   = wrap_inc(r_owner);
               end
            end
         end
         default: begin
            w_state_nxt = ALLOC_IDLE;
         end
      endcase
      // Reset state alone would still allow an IDLE grant, so mask explicitly.
      if (rst_noc) begin
         w_grant = '0;
      end
   end

   assign w_send = |w_grant;

   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         r_state <= ALLOC_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // A grant is only possible with a non-zero count, so the decrement never wraps.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         r_credit   <= c_full;
         r_overflow <= 1'b0;
      end else begin
         if (w_send && !credit_in) begin
            r_credit <= r_credit - c_one;
         end else if (!w_send && credit_in) begin
            if (r_credit == c_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_credit <= r_credit + c_one;
            end
         end
      end
   end

   assign grant           = w_grant;
   assign send_out        = w_send;
   assign is_tail_out     = |(w_grant & req_is_tail);
   assign credit_count    = r_credit;
   assign locked          = (r_state == ALLOC_LOCKED);
   assign owner           = r_owner;
   assign credit_overflow = r_overflow;

endmodule : output_port_allocator
`default_nettype wire

// File: doc/output_port_allocator.md
OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, number of router input ports competing for this output.
REQ-002 SHALL have parameter FLIT_BUFFER_DEPTH, default 2, downstream input-buffer depth in flits; it is also the initial credit count.
REQ-003 SHALL have localparam CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH+1) and IDX_WIDTH = $clog2(NUM_INPUTS).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_noc  input  1  NoC clock; all state on rising edge.
REQ-006 rst_noc  input  1  asynchronous active-high reset.
REQ-007 req  input  NUM_INPUTS  per-input request; a head or body flit targeting this output is at the buffer head.
REQ-008 req_is_tail  input  NUM_INPUTS  per-input: the requesting flit is a packet tail.
REQ-009 credit_in  input  1  one downstream buffer slot freed this cycle.
REQ-010 grant  output  NUM_INPUTS  one-hot or zero; the granted input dequeues its flit this cycle.
REQ-011 send_out  output  1  a flit crosses to downstream this cycle; equals |grant.
REQ-012 is_tail_out  output  1  the granted flit is a tail.
REQ-013 credit_count  output  CREDIT_WIDTH  current registered credit count.
REQ-014 locked  output  1  a multi-flit packet holds this output.
REQ-015 owner  output  IDX_WIDTH  index of the locking input; valid when locked=1.
REQ-016 credit_overflow  output  1  sticky error flag.

Function
REQ-017 SHALL implement the FSM IDLE/LOCKED with a registered round-robin priority pointer ptr (IDX_WIDTH).
REQ-018 grant SHALL be combinational from req, req_is_tail and registered state: zero cycles of latency from req to grant.
REQ-019 SHALL drive no grant when credit_count == 0, using the registered count only; credit_in does not bypass.
REQ-020 In IDLE with credit_count > 0 and req != 0, SHALL grant the first asserted req at or after ptr, wrapping from NUM_INPUTS-1 to 0.
REQ-021 On an IDLE grant with req_is_tail[w] = 1 (single-flit packet), SHALL remain IDLE and set ptr = w+1 mod NUM_INPUTS.
REQ-022 On an IDLE grant with req_is_tail[w] = 0, SHALL enter LOCKED with owner = w; ptr is unchanged.
REQ-023 In LOCKED, SHALL grant only the owner, when req[owner] = 1 and credit_count > 0; requests from other inputs are ignored.
REQ-024 In LOCKED, if the owner deasserts req mid-packet, SHALL hold the lock and issue no grant.
REQ-025 On a LOCKED grant with req_is_tail[owner] = 1, SHALL return to IDLE and set ptr = owner+1 mod NUM_INPUTS.
REQ-026 credit_count SHALL update as: minus 1 on send_out, plus 1 on credit_in, unchanged when both occur in the same cycle.
REQ-027 If credit_in arrives at credit_count == FLIT_BUFFER_DEPTH without send_out, SHALL saturate the count and set credit_overflow until reset.
REQ-028 is_tail_out SHALL equal req_is_tail of the granted input, and 0 when there is no grant.

Reset
REQ-029 On rst_noc SHALL set: state IDLE, ptr 0, owner 0, credit_count = FLIT_BUFFER_DEPTH, credit_overflow 0, locked 0.
REQ-030 grant, send_out and is_tail_out SHALL be 0 while rst_noc is asserted.
REQ-031 Reset asserted mid-packet SHALL drop the lock and restore full credits immediately (asynchronously).

Structure
REQ-032 noc_router_pkg SHALL hold the alloc_state_t enum (ALLOC_IDLE, ALLOC_LOCKED) and the credit-width helper function.
REQ-033 SHALL instantiate one combinational sub-module rr_arbiter (NUM_INPUTS, one-hot output, priority from ptr).
REQ-034 The router SHALL instantiate one allocator per output port.

Verification
REQ-035 Reset release, req=5'b00000 -> grant=0, credit_count=2, locked=0.
REQ-036 req=5'b10010, tails=5'b10010, credits ample -> grant sequence 00010, 10000, 00010 (round-robin, ptr wraps).
REQ-037 Input 1 sends a 3-flit packet while input 3 requests continuously -> input 1 is granted for 3 flits, locked=1 until the tail, then input 3 is granted.
REQ-038 Depth 2, no credit_in, owner streaming -> two grants, then credit_count=0 and grant=0; a credit_in pulse -> exactly one grant on the following cycle.
REQ-039 send_out and credit_in in the same cycle at count=1 -> count stays 1; credit_in at count=2 with no send -> count stays 2 and credit_overflow=1.
REQ-040 rst_noc asserted while LOCKED after 1 flit -> immediately locked=0, grant=0; after release, credit_count=2 and ptr=0.
